// File: rtl/pe_mac_array_cell_pkg.sv
// Shared types and default widths for the systolic MAC array cell.
package pe_mac_array_cell_pkg;

    typedef enum logic [1:0] {
        ACC  = 2'd0,
        SELF = 2'd1,
        PASS = 2'd2
    } cell_state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ACC_W  = 24;

endpackage

// File: rtl/pe_mac_array_cell_mac_sat.sv
// pe_mac_sat: combinational extend-multiply-accumulate step of the array cell.
// Defining PE_SATURATE_EN clamps at the signed/unsigned accumulator limits instead of wrapping.
module pe_mac_sat
    import pe_mac_array_cell_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              signed_mode,
    input  logic [ACC_W-1:0]  acc,
    output logic [ACC_W-1:0]  sum,
    output logic              clamped
);

    localparam int PROD_W = 2 * DATA_W;

    logic signed [PROD_W-1:0] prod_s;
    logic        [PROD_W-1:0] prod_u;
    logic signed [ACC_W-1:0]  ext_s;
    logic        [ACC_W-1:0]  ext_u;
    logic        [ACC_W-1:0]  addend;

    assign prod_s = $signed(a) * $signed(b);
    assign prod_u = a * b;
    // The size cast of a signed value sign-extends; of an unsigned value zero-extends.
    assign ext_s  = ACC_W'(prod_s);
    assign ext_u  = ACC_W'(prod_u);
    assign addend = signed_mode ? ext_s : ext_u;

`ifdef PE_SATURATE_EN
    // Returns {clamped, result}.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] x,
                                               input logic [ACC_W-1:0] y,
                                               input logic             sm);
        logic [ACC_W:0] raw;
        raw = {1'b0, x} + {1'b0, y};
        if (sm) begin
            if ((x[ACC_W-1] == y[ACC_W-1]) && (raw[ACC_W-1] != x[ACC_W-1])) begin
                if (x[ACC_W-1])
                    return {1'b1, 1'b1, {(ACC_W-1){1'b0}}};
                else
                    return {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
            end
        end else if (raw[ACC_W]) begin
            return {1'b1, {ACC_W{1'b1}}};
        end
        return {1'b0, raw[ACC_W-1:0]};
    endfunction

    assign {clamped, sum} = sat_add(acc, addend, signed_mode);
`else
    assign sum     = acc + addend;
    assign clamped = 1'b0;
`endif

endmodule

// File: rtl/pe_mac_array_cell.sv
// Systolic MAC array cell: operand forwarding, accumulate, and daisy-chained result drain.
// Saturation is selected by PE_SATURATE_EN inside pe_mac_sat; otherwise acc_overflow stays 0.
module pe_mac_array_cell
    import pe_mac_array_cell_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int CHAIN_POS = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              signed_mode,
    input  logic [DATA_W-1:0] a_in,
    input  logic              a_valid_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              b_valid_in,
    output logic [DATA_W-1:0] a_out,
    output logic              a_valid_out,
    output logic [DATA_W-1:0] b_out,
    output logic              b_valid_out,
    input  logic              drain,
    input  logic [ACC_W-1:0]  c_in,
    input  logic              c_valid_in,
    output logic [ACC_W-1:0]  c_out,
    output logic              c_valid_out,
    output logic              busy,
    output logic              acc_overflow
);

    localparam logic [7:0] LAST_BEAT = 8'((CHAIN_POS > 0) ? CHAIN_POS - 1 : 0);

    cell_state_t      state;
    logic [ACC_W-1:0] acc;
    logic [7:0]       pass_cnt;
    logic [ACC_W-1:0] mac_sum;
    logic             mac_clamp;
    logic             mac_en;

    assign mac_en = a_valid_in && b_valid_in;

    pe_mac_sat #(
        .DATA_W(DATA_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .a          (a_in),
        .b          (b_in),
        .signed_mode(signed_mode),
        .acc        (acc),
        .sum        (mac_sum),
        .clamped    (mac_clamp)
    );

    // Operand forwarding runs independently of the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out       <= '0;
            a_valid_out <= 1'b0;
            b_out       <= '0;
            b_valid_out <= 1'b0;
        end else begin
            a_valid_out <= a_valid_in;
            b_valid_out <= b_valid_in;
            if (a_valid_in) a_out <= a_in;
            if (b_valid_in) b_out <= b_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ACC;
            acc          <= '0;
            pass_cnt     <= '0;
            c_out        <= '0;
            c_valid_out  <= 1'b0;
            busy         <= 1'b0;
            acc_overflow <= 1'b0;
        end else if (clear) begin
            state        <= ACC;
            acc          <= '0;
            pass_cnt     <= '0;
            c_valid_out  <= 1'b0;
            busy         <= 1'b0;
            acc_overflow <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    c_valid_out <= 1'b0;
                    // A drain snapshots the accumulator; a coincident pair is not added.
                    if (drain) begin
                        state       <= SELF;
                        c_out       <= acc;
                        c_valid_out <= 1'b1;
                        busy        <= 1'b1;
                    end else if (mac_en) begin
                        acc <= mac_sum;
                        if (mac_clamp) acc_overflow <= 1'b1;
                    end
                end
                SELF: begin
                    c_valid_out <= 1'b0;
                    pass_cnt    <= '0;
                    if (CHAIN_POS > 0) begin
                        state <= PASS;
                    end else begin
                        state <= ACC;
                        acc   <= '0;
                        busy  <= 1'b0;
                    end
                end
                PASS: begin
                    c_out       <= c_in;
                    c_valid_out <= c_valid_in;
                    if (c_valid_in) begin
                        if (pass_cnt == LAST_BEAT) begin
                            state    <= ACC;
                            acc      <= '0;
                            busy     <= 1'b0;
                            pass_cnt <= '0;
                        end else begin
                            pass_cnt <= pass_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    state <= ACC;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_mac_array_cell.sv
// Directed bench: a default cell (CHAIN_POS=0) and a 16-bit cell with CHAIN_POS=2 share stimulus.
module tb_pe_mac_array_cell;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        signed_mode;
    logic [7:0]  a_in, b_in;
    logic        a_valid_in, b_valid_in;
    logic        drain0, drain1;
    logic [23:0] c_in0;
    logic [15:0] c_in1;
    logic        c_valid_in;

    logic [7:0]  a_out0, b_out0, a_out1, b_out1;
    logic        a_valid_out0, b_valid_out0, a_valid_out1, b_valid_out1;
    logic [23:0] c_out0;
    logic [15:0] c_out1;
    logic        c_valid_out0, c_valid_out1, busy0, busy1, ovf0, ovf1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pe_mac_array_cell dut0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .signed_mode(signed_mode),
        .a_in(a_in), .a_valid_in(a_valid_in), .b_in(b_in), .b_valid_in(b_valid_in),
        .a_out(a_out0), .a_valid_out(a_valid_out0), .b_out(b_out0), .b_valid_out(b_valid_out0),
        .drain(drain0), .c_in(c_in0), .c_valid_in(c_valid_in),
        .c_out(c_out0), .c_valid_out(c_valid_out0), .busy(busy0), .acc_overflow(ovf0)
    );

    pe_mac_array_cell #(.DATA_W(8), .ACC_W(16), .CHAIN_POS(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .signed_mode(signed_mode),
        .a_in(a_in), .a_valid_in(a_valid_in), .b_in(b_in), .b_valid_in(b_valid_in),
        .a_out(a_out1), .a_valid_out(a_valid_out1), .b_out(b_out1), .b_valid_out(b_valid_out1),
        .drain(drain1), .c_in(c_in1), .c_valid_in(c_valid_in),
        .c_out(c_out1), .c_valid_out(c_valid_out1), .busy(busy1), .acc_overflow(ovf1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] exp_sat;
        logic        exp_ovf;
`ifdef PE_SATURATE_EN
        exp_sat = 16'd65535;
        exp_ovf = 1'b1;
`else
        exp_sat = 16'd64514;
        exp_ovf = 1'b0;
`endif
        rst_n = 1'b0; clear = 1'b0; signed_mode = 1'b0;
        a_in = '0; b_in = '0; a_valid_in = 1'b0; b_valid_in = 1'b0;
        drain0 = 1'b0; drain1 = 1'b0; c_in0 = '0; c_in1 = '0; c_valid_in = 1'b0;

        // Reset state
        step(); step();
        chk("rst_c_out", 32'(c_out0), 32'd0);
        chk("rst_c_valid", 32'(c_valid_out0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_a_out", 32'(a_out0), 32'd0);
        chk("rst_ovf", 32'(ovf0), 32'd0);
        rst_n = 1'b1;
        step();

        // Unsigned (3,4),(5,6) -> 42
        a_in = 8'd3; b_in = 8'd4; a_valid_in = 1'b1; b_valid_in = 1'b1;
        step();
        a_in = 8'd5; b_in = 8'd6;
        step();
        chk("fwd_a_out", 32'(a_out0), 32'd5);
        chk("fwd_a_valid", 32'(a_valid_out0), 32'd1);
        chk("fwd_b_out", 32'(b_out0), 32'd6);
        a_valid_in = 1'b0; b_valid_in = 1'b0; drain0 = 1'b1;
        step();
        drain0 = 1'b0;
        chk("u_self_c_out", 32'(c_out0), 32'd42);
        chk("u_self_valid", 32'(c_valid_out0), 32'd1);
        chk("u_self_busy", 32'(busy0), 32'd1);
        step();
        chk("u_after_valid", 32'(c_valid_out0), 32'd0);
        chk("u_after_busy", 32'(busy0), 32'd0);
        chk("u_after_hold", 32'(c_out0), 32'd42);
        chk("fwd_a_valid_drop", 32'(a_valid_out0), 32'd0);
        chk("fwd_a_hold", 32'(a_out0), 32'd5);

        // Signed (-3,4),(2,2) -> -8
        clear = 1'b1;
        step();
        clear = 1'b0; signed_mode = 1'b1;
        a_in = 8'hFD; b_in = 8'd4; a_valid_in = 1'b1; b_valid_in = 1'b1;
        step();
        a_in = 8'd2; b_in = 8'd2;
        step();
        a_valid_in = 1'b0; b_valid_in = 1'b0; drain0 = 1'b1;
        step();
        drain0 = 1'b0;
        chk("s_self_c_out", 32'(c_out0), 32'h00FF_FFF8);
        chk("s_self_valid", 32'(c_valid_out0), 32'd1);
        step();

        // Chain pass-through on dut1 (CHAIN_POS=2)
        clear = 1'b1;
        step();
        clear = 1'b0; signed_mode = 1'b0;
        a_in = 8'd2; b_in = 8'd3; a_valid_in = 1'b1; b_valid_in = 1'b1;
        step();
        a_valid_in = 1'b0; b_valid_in = 1'b0; drain1 = 1'b1;
        step();
        drain1 = 1'b0;
        chk("ch_own_c_out", 32'(c_out1), 32'd6);
        chk("ch_own_valid", 32'(c_valid_out1), 32'd1);
        chk("ch_own_busy", 32'(busy1), 32'd1);
        step();
        chk("ch_pass_idle_valid", 32'(c_valid_out1), 32'd0);
        chk("ch_pass_busy", 32'(busy1), 32'd1);
        c_in1 = 16'd7; c_valid_in = 1'b1;
        step();
        chk("ch_beat1_c_out", 32'(c_out1), 32'd7);
        chk("ch_beat1_valid", 32'(c_valid_out1), 32'd1);
        chk("ch_beat1_busy", 32'(busy1), 32'd1);
        c_in1 = 16'd9;
        step();
        chk("ch_beat2_c_out", 32'(c_out1), 32'd9);
        chk("ch_beat2_valid", 32'(c_valid_out1), 32'd1);
        chk("ch_done_busy", 32'(busy1), 32'd0);
        c_valid_in = 1'b0;
        step();
        chk("ch_acc_valid", 32'(c_valid_out1), 32'd0);
        drain1 = 1'b1;
        step();
        drain1 = 1'b0;
        chk("ch_acc_cleared", 32'(c_out1), 32'd0);
        step();
        c_in1 = 16'd1; c_valid_in = 1'b1;
        step(); step();
        c_valid_in = 1'b0;
        step();
        chk("ch_second_done_busy", 32'(busy1), 32'd0);

        // clear beats drain in the same cycle
        clear = 1'b1;
        step();
        clear = 1'b0;
        a_in = 8'd10; b_in = 8'd10; a_valid_in = 1'b1; b_valid_in = 1'b1;
        step();
        a_valid_in = 1'b0; b_valid_in = 1'b0; clear = 1'b1; drain0 = 1'b1;
        step();
        clear = 1'b0; drain0 = 1'b0;
        chk("clr_valid", 32'(c_valid_out0), 32'd0);
        chk("clr_busy", 32'(busy0), 32'd0);
        step();
        chk("clr_valid_later", 32'(c_valid_out0), 32'd0);
        drain0 = 1'b1;
        step();
        drain0 = 1'b0;
        chk("clr_acc_zero", 32'(c_out0), 32'd0);
        chk("clr_drain_valid", 32'(c_valid_out0), 32'd1);
        step();

        // 255*255 twice into a 16-bit accumulator
        clear = 1'b1;
        step();
        clear = 1'b0; signed_mode = 1'b0;
        a_in = 8'd255; b_in = 8'd255; a_valid_in = 1'b1; b_valid_in = 1'b1;
        step(); step();
        a_valid_in = 1'b0; b_valid_in = 1'b0; drain1 = 1'b1;
        step();
        drain1 = 1'b0;
        chk("wrap_c_out", 32'(c_out1), 32'(exp_sat));
        chk("wrap_ovf", 32'(ovf1), 32'(exp_ovf));
        step();
        chk("pre_rst_busy", 32'(busy1), 32'd1);

        // Asynchronous reset while in PASS
        rst_n = 1'b0;
        #1;
        chk("arst_c_out", 32'(c_out1), 32'd0);
        chk("arst_valid", 32'(c_valid_out1), 32'd0);
        chk("arst_busy", 32'(busy1), 32'd0);
        chk("arst_a_out", 32'(a_out1), 32'd0);
        chk("arst_ovf", 32'(ovf1), 32'd0);
        step(); step();
        rst_n = 1'b1;
        c_in1 = 16'd5; c_valid_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_valid", 32'(c_valid_out1), 32'd0);
            chk("post_rst_busy", 32'(busy1), 32'd0);
        end
        c_valid_in = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_mac_array_cell.md
PE_MAC_ARRAY_CELL -- requirements
Module: pe_mac_array_cell

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand width.
REQ-002 SHALL have parameter ACC_W, default 24, accumulator width; legal only if ACC_W >= 2*DATA_W.
REQ-003 SHALL have parameter CHAIN_POS, default 0, number of upstream cells whose results pass through this cell during drain (0..255).
REQ-004 SHALL have ports: clk  in  1  clock, rising edge; one clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: clear  in  1  sync accumulator clear; signed_mode  in  1  1=two's-complement operands, 0=unsigned.
REQ-006 SHALL have ports: a_in  in  DATA_W  west operand; a_valid_in  in  1; b_in  in  DATA_W  north operand; b_valid_in  in  1.
REQ-007 SHALL have ports: a_out  out  DATA_W  east operand; a_valid_out  out  1; b_out  out  DATA_W  south operand; b_valid_out  out  1.
REQ-008 SHALL have ports: drain  in  1  start result drain; c_in  in  ACC_W  upstream result; c_valid_in  in  1.
REQ-009 SHALL have ports: c_out  out  ACC_W  result chain; c_valid_out  out  1; busy  out  1  high outside ACC; acc_overflow  out  1  sticky overflow.

Function
REQ-010 SHALL forward a_in/a_valid_in to a_out/a_valid_out and b_in/b_valid_in to b_out/b_valid_out with exactly 1-cycle latency in every state; data registers load only when the matching valid is high.
REQ-011 SHALL implement states ACC, SELF, PASS.
REQ-012 In ACC, when a_valid_in && b_valid_in, SHALL add product a_in*b_in to the accumulator, result visible next cycle.
REQ-013 Product SHALL be 2*DATA_W wide, signed or unsigned per signed_mode sampled the same cycle, sign- or zero-extended to ACC_W before add.
REQ-014 Without saturation, accumulation SHALL wrap modulo 2^ACC_W.
REQ-015 ACC + drain SHALL transition to SELF; SELF SHALL drive c_out=accumulator, c_valid_out=1 for exactly one cycle.
REQ-016 SELF SHALL go to PASS if CHAIN_POS>0, else to ACC with accumulator cleared.
REQ-017 PASS SHALL drive c_out<=c_in, c_valid_out<=c_valid_in (1-cycle latency), count c_valid_in beats, and return to ACC with accumulator cleared after CHAIN_POS beats.
REQ-018 In SELF/PASS, operand pairs SHALL be forwarded but not accumulated; drain SHALL be ignored.
REQ-019 In ACC, c_valid_out SHALL be 0 and c_out SHALL hold its last value.
REQ-020 clear SHALL zero accumulator, pass counter and acc_overflow, and force ACC, with priority over drain and MAC in the same cycle.
REQ-021 busy SHALL be 1 in SELF and PASS, 0 in ACC.

Reset
REQ-022 rst_n low SHALL asynchronously force state ACC and zero accumulator, counter, a_out, b_out, c_out, all valid outputs, busy and acc_overflow.
REQ-023 Reset mid-drain SHALL abandon the drain; no further c_valid_out after rst_n deasserts.

Configuration
REQ-024 Macro PE_SATURATE_EN defined: accumulator SHALL clamp at signed (signed_mode=1) or unsigned (signed_mode=0) ACC_W max/min instead of wrapping, and acc_overflow SHALL set on any clamp and stay set until clear or reset.
REQ-025 Macro undefined: wrap per REQ-014, acc_overflow SHALL be constant 0.

Structure
REQ-026 A shared package SHALL hold the state enum (ACC, SELF, PASS) and the default DATA_W/ACC_W constants.
REQ-027 A sub-module pe_mac_sat SHALL contain the extend-multiply-add (and clamp when enabled), purely combinational; the FSM, forwarding and chain registers live in the top.

Verification
REQ-028 Unsigned, DATA_W=8: pairs (3,4),(5,6) valid, then drain -> SELF cycle c_out=42, c_valid_out=1, busy=1.
REQ-029 signed_mode=1: pairs (-3,4),(2,2) -> drained c_out=-8 sign-represented in ACC_W.
REQ-030 CHAIN_POS=2: drain, feed c_in=7 then 9 with c_valid_in -> c_out sequence own,7,9 valid, then ACC with accumulator 0, busy=0.
REQ-031 clear and drain same cycle with accumulator 100 -> state ACC, accumulator 0, no c_valid_out.
REQ-032 ACC_W=16, unsigned, 255*255 twice: wrap gives 64514 with macro undefined; 65535 and acc_overflow=1 with PE_SATURATE_EN.
REQ-033 rst_n asserted during PASS -> all outputs 0 immediately, ACC after release, no stray c_valid_out.
